// File: rtl/ov5640_init_seq.sv
// ov5640_init_seq: writes the OV5640 register init table through an I2C master,
// with power-up wait, inter-write gap, per-entry NACK retry and start timeout.
module ov5640_init_seq #(
  parameter int NUM_REGS      = 4,
  parameter int STARTUP_WAIT  = 250,
  parameter int GAP_WAIT      = 125,
  parameter int MAX_RETRY     = 3,
  parameter int START_TIMEOUT = 200
) (
  input  logic        ack_clk,
  input  logic        reset,
  input  logic        start,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  output logic [23:0] send_dat,
  output logic        sendit,
  output logic [7:0]  index,
  output logic        busy,
  output logic        init_done,
  output logic        init_error
);
  localparam int MW0      = STARTUP_WAIT > GAP_WAIT ? STARTUP_WAIT : GAP_WAIT;
  localparam int MAX_WAIT = MW0 > START_TIMEOUT ? MW0 : START_TIMEOUT;
  localparam int CW       = MAX_WAIT > 0 ? $clog2(MAX_WAIT + 1) : 1;
  localparam int RW       = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [23:0] ROM [4] = '{24'h310311, 24'h300882, 24'h300842, 24'h300802};
  typedef enum logic [3:0] {
    IDLE, POWER_WAIT, LOAD, ISSUE, WAIT_START, WAIT_END, CHECK, GAP, FINISH, FAIL
  } state_t;
  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [RW-1:0]   retry, retry_n;
  logic [7:0]      index_n;
  logic [23:0]     send_dat_n, rom_word;
  logic            sendit_n, done_n, err_n;
  logic            start_low, start_edge;
  logic            pw_last, gap_last, to_last, retry_ok, more;
  // start_low resets to 0, so a start held high through reset is never an edge
  assign start_edge = start & start_low;
  assign rom_word   = (index < 8'd4) ? ROM[index[1:0]] : 24'h000000;
  assign pw_last    = int'(cnt) + 1 >= STARTUP_WAIT;
  assign gap_last   = int'(cnt) + 1 >= GAP_WAIT;
  assign to_last    = int'(cnt) + 1 >= START_TIMEOUT;
  assign retry_ok   = int'(retry) < MAX_RETRY;
  assign more       = int'(index) < NUM_REGS;
  assign busy       = !(state == IDLE || state == FINISH || state == FAIL);
  always_comb begin
    state_n    = state;
    cnt_n      = '0;
    retry_n    = retry;
    index_n    = index;
    send_dat_n = send_dat;
    sendit_n   = sendit;
    done_n     = init_done;
    err_n      = init_error;
    case (state)
      IDLE, FINISH, FAIL:
        if (start_edge) begin
          state_n = POWER_WAIT;
          index_n = '0;
          retry_n = '0;
          done_n  = 1'b0;
          err_n   = 1'b0;
        end
      POWER_WAIT:
        if (pw_last) state_n = LOAD;
        else cnt_n = cnt + 1'b1;
      LOAD: begin
        send_dat_n = rom_word;
        state_n    = ISSUE;
      end
      ISSUE: begin
        sendit_n = 1'b1;
        state_n  = WAIT_START;
      end
      WAIT_START:
        if (!i2c_done) state_n = WAIT_END;
        else if (to_last) begin
          state_n  = FAIL;
          sendit_n = 1'b0;
          err_n    = 1'b1;
        end else cnt_n = cnt + 1'b1;
      WAIT_END:
        if (i2c_done) begin
          sendit_n = 1'b0;
          state_n  = CHECK;
        end
      CHECK:
        if (!i2c_nack) begin
          retry_n = '0;
          index_n = index + 8'd1;
          state_n = GAP;
        end else if (retry_ok) begin
          retry_n = retry + 1'b1;
          state_n = GAP;
        end else begin
          state_n = FAIL;
          err_n   = 1'b1;
        end
      GAP:
        if (gap_last) begin
          state_n = more ? LOAD : FINISH;
          done_n  = !more;
        end else cnt_n = cnt + 1'b1;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge ack_clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      retry      <= '0;
      index      <= '0;
      send_dat   <= '0;
      sendit     <= 1'b0;
      init_done  <= 1'b0;
      init_error <= 1'b0;
      start_low  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      retry      <= retry_n;
      index      <= index_n;
      send_dat   <= send_dat_n;
      sendit     <= sendit_n;
      init_done  <= done_n;
      init_error <= err_n;
      start_low  <= ~start;
    end
  end
endmodule

// File: doc/ov5640_init_seq.md
OV5640_INIT_SEQ -- requirements
Module: ov5640_init_seq

Interface
REQ-001 SHALL have parameter NUM_REGS, default 4, number of ROM entries written per sequence (1..255).
REQ-002 SHALL have parameter STARTUP_WAIT, default 250, ack_clk cycles between start and the first write.
REQ-003 SHALL have parameter GAP_WAIT, default 125, ack_clk idle cycles between consecutive writes.
REQ-004 SHALL have parameter MAX_RETRY, default 3, re-sends allowed per entry after a NACK.
REQ-005 SHALL have parameter START_TIMEOUT, default 200, ack_clk cycles allowed for the master to drop i2c_done after sendit rises.
REQ-006 SHALL have port ack_clk  input  1  clock, all state on rising edge.
REQ-007 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port start  input  1  rising edge begins a sequence when idle.
REQ-009 SHALL have port i2c_done  input  1  master idle flag (1 = idle/finished).
REQ-010 SHALL have port i2c_nack  input  1  master NACK flag, valid while i2c_done=1 after a transfer.
REQ-011 SHALL have port send_dat  output  24  {reg_addr[15:0], reg_data[7:0]} for the master.
REQ-012 SHALL have port sendit  output  1  transfer request to the master.
REQ-013 SHALL have port index  output  8  current ROM entry number.
REQ-014 SHALL have port busy  output  1  sequence in progress.
REQ-015 SHALL have port init_done  output  1  sticky, all entries acknowledged.
REQ-016 SHALL have port init_error  output  1  sticky, sequence aborted.

Function
REQ-017 SHALL hold an internal ROM: entry 0 = 24'h310311, 1 = 24'h300882, 2 = 24'h300842, 3 = 24'h300802; entries >= 4 are 24'h000000.
REQ-018 SHALL implement states IDLE, POWER_WAIT, LOAD, ISSUE, WAIT_START, WAIT_END, CHECK, GAP, FINISH, FAIL.
REQ-019 SHALL detect start rising edge with a 1-cycle registered copy; in IDLE an edge moves to POWER_WAIT, index cleared, retry count cleared, init_done and init_error cleared.
REQ-020 SHALL ignore start edges in all states other than IDLE, FINISH and FAIL; in FINISH/FAIL an edge restarts as from IDLE.
REQ-021 SHALL count STARTUP_WAIT cycles in POWER_WAIT, then go to LOAD.
REQ-022 SHALL in LOAD register ROM[index] into send_dat (1 cycle), then go to ISSUE.
REQ-023 SHALL in ISSUE assert sendit (registered) and go to WAIT_START; send_dat SHALL be stable whenever sendit=1.
REQ-024 SHALL in WAIT_START keep sendit=1 until i2c_done=0, then go to WAIT_END; if START_TIMEOUT cycles elapse first, go to FAIL.
REQ-025 SHALL in WAIT_END keep sendit=1 until i2c_done=1, deassert sendit on the next edge, and go to CHECK.
REQ-026 SHALL in CHECK: i2c_nack=0 -> clear retry count, increment index, go to GAP; i2c_nack=1 and retry count < MAX_RETRY -> increment retry count, go to GAP without incrementing index; otherwise go to FAIL.
REQ-027 SHALL count GAP_WAIT cycles in GAP with sendit=0, then go to LOAD if index < NUM_REGS, else FINISH.
REQ-028 SHALL in FINISH set init_done=1, busy=0, sendit=0; in FAIL set init_error=1, busy=0, sendit=0; index holds the failing or final value.
REQ-029 SHALL drive busy=1 in every state except IDLE, FINISH and FAIL.
REQ-030 SHALL size the wait counter to hold max(STARTUP_WAIT, GAP_WAIT, START_TIMEOUT) with no wrap; retry count width SHALL be clog2(MAX_RETRY+1).
REQ-031 SHALL never assert init_done and init_error together.

Reset
REQ-032 SHALL on reset=1, at any time including mid-transfer, immediately force state IDLE, sendit=0, send_dat=0, index=0, busy=0, init_done=0, init_error=0, counters=0, start-edge register=0.
REQ-033 SHALL, if start is held high through reset release, not treat it as an edge; a new 0->1 transition is required.

Verification
REQ-034 Start pulse, master model ACKs all -> first sendit rise 250+2 cycles after edge, send_dat sequence 310311, 300882, 300842, 300802, init_done=1, index=4.
REQ-035 Master NACKs entry 1 twice then ACKs -> entry 1 sent 3 times with send_dat=300882 each time, init_done=1, init_error=0.
REQ-036 Master NACKs entry 2 four times -> 4 sends of 300842, then init_error=1, index=2, sendit=0.
REQ-037 Master never drops i2c_done -> init_error=1 exactly 200 cycles after sendit rises, index=0.
REQ-038 reset asserted during WAIT_END of entry 1 -> sendit=0, busy=0, index=0 asynchronously; new start replays from entry 0.
REQ-039 Start edges during busy and start held high across reset release -> no effect; consecutive sendit pulses separated by >= 125 low cycles.
